// File: rtl/multicycle_ctrl_pkg.sv
// Package: multicycle_ctrl_pkg
// Shared definitions for the multicycle RV32I control FSM, the datapath and ALU control:
//   - state_t : the 14 sequencing states (4-bit encoding)
//   - OPC_*   : RV32I major opcodes (IR[6:0])
//   - SRC_B_* / ALU_OP_* / M2R_* : mux-select and ALU-op encodings driven by the FSM
//   - id_next_state() : opcode dispatch used in the ID state
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF,
    S_ID,
    S_EX_ALU,
    S_WB_ALU,
    S_EX_ADDR,
    S_MEM_LD,
    S_WB_LD,
    S_MEM_ST,
    S_EX_BR,
    S_EX_JAL,
    S_EX_JALR,
    S_WB_JALR,
    S_PC4,
    S_HALT
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // alu_src_b; encoding 3 is reserved and never driven
  localparam logic [1:0] SRC_B_REG  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  localparam logic [1:0] ALU_OP_ADD    = 2'd0;
  localparam logic [1:0] ALU_OP_BRANCH = 2'd1;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'd2;
  localparam logic [1:0] ALU_OP_ITYPE  = 2'd3;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_ALU    = 2'd2;

  // Successor of ID, chosen from the freshly latched opcode.
  function automatic state_t id_next_state(input logic [6:0] opc,
                                           input logic       ecall_halt,
                                           input logic       halt_on_illegal);
    case (opc)
      OPC_OP, OPC_OP_IMM:  return S_EX_ALU;
      OPC_LOAD, OPC_STORE: return S_EX_ADDR;
      OPC_BRANCH:          return S_EX_BR;
      OPC_JAL:             return S_EX_JAL;
      OPC_JALR:            return S_EX_JALR;
      OPC_SYSTEM:          return ecall_halt ? S_HALT : S_PC4;
      default:             return halt_on_illegal ? S_HALT : S_PC4;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_perf_counters.sv
// Module: ctrl_perf_counters
// Cycle and retired-instruction counters for the multicycle control FSM.
// Only built when MULTICYCLE_CTRL_STATS_EN is defined.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   cycle_inc         count this cycle
//   instret_inc       one instruction retires this cycle
//   cycle_cnt         free-running cycle count, wraps modulo 2^CNT_W
//   instret_cnt       retired-instruction count, wraps modulo 2^CNT_W
`ifdef MULTICYCLE_CTRL_STATS_EN
module ctrl_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cycle_inc,
  input  logic             instret_inc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (cycle_inc)   cycle_cnt   <= cycle_cnt + CNT_W'(1);
      if (instret_inc) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/multicycle_ctrl_fsm.sv
// Module: multicycle_ctrl_fsm
// Sequencing FSM for the multicycle RV32I datapath (shared memory, IR/MDR/A/B/ALUOut).
// One state per cycle; memory states wait on mem_ready; ECALL with x17==10 halts.
// Optional feature macro: MULTICYCLE_CTRL_STATS_EN adds cycle_cnt / instret_cnt outputs.
// Ports:
//   clk, reset     clock (rising edge), asynchronous active-low reset
//   opcode         IR[6:0], valid from ID onward
//   alu_bcond      branch condition from ALU (1 = taken)
//   ecall_halt     x17==10 from register-file compare
//   mem_ready      memory completes the current access this cycle
//   pc_update, pc_source, i_or_d, mem_read, mem_write, ir_write, mdr_write,
//   a_write, b_write, aluout_write, alu_src_a, alu_src_b, alu_op,
//   reg_write, mem_to_reg   datapath enables and mux selects
//   is_halted      sticky halt flag (cleared only by reset)
//   cycle_cnt, instret_cnt  performance counters (macro only)
module multicycle_ctrl_fsm
  import multicycle_ctrl_pkg::*;
#(
  parameter int HALT_ON_ILLEGAL = 0
`ifdef MULTICYCLE_CTRL_STATS_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       ecall_halt,
  input  logic       mem_ready,
  output logic       pc_update,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       a_write,
  output logic       b_write,
  output logic       aluout_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       is_halted
`ifdef MULTICYCLE_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  state_t state, next_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IF;
    else        state <= next_state;
  end

  // Outputs are decoded from the current state (plus mem_ready / alu_bcond in the
  // handshake and branch states) and forced low while reset is held.
  always_comb begin
    next_state   = state;
    pc_update    = 1'b0;
    pc_source    = 1'b0;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    mdr_write    = 1'b0;
    a_write      = 1'b0;
    b_write      = 1'b0;
    aluout_write = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRC_B_REG;
    alu_op       = ALU_OP_ADD;
    reg_write    = 1'b0;
    mem_to_reg   = M2R_ALUOUT;
    is_halted    = 1'b0;

    if (reset) begin
      case (state)
        S_IF: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            next_state = S_ID;
          end
        end
        S_ID: begin
          // Register read and speculative branch/JAL target PC+imm into ALUOut.
          a_write      = 1'b1;
          b_write      = 1'b1;
          aluout_write = 1'b1;
          alu_src_b    = SRC_B_IMM;
          next_state   = id_next_state(opcode, ecall_halt, (HALT_ON_ILLEGAL != 0));
        end
        S_EX_ALU: begin
          alu_src_a    = 1'b1;
          aluout_write = 1'b1;
          if (opcode == OPC_OP) begin
            alu_src_b = SRC_B_REG;
            alu_op    = ALU_OP_RTYPE;
          end else begin
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_OP_ITYPE;
          end
          next_state = S_WB_ALU;
        end
        S_WB_ALU: begin
          reg_write  = 1'b1;
          pc_update  = 1'b1;
          alu_src_b  = SRC_B_FOUR;
          next_state = S_IF;
        end
        S_EX_ADDR, S_EX_JALR: begin
          alu_src_a    = 1'b1;
          alu_src_b    = SRC_B_IMM;
          aluout_write = 1'b1;
          if (state == S_EX_JALR)      next_state = S_WB_JALR;
          else if (opcode == OPC_LOAD) next_state = S_MEM_LD;
          else                         next_state = S_MEM_ST;
        end
        S_MEM_LD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready) begin
            mdr_write  = 1'b1;
            next_state = S_WB_LD;
          end
        end
        S_WB_LD: begin
          reg_write  = 1'b1;
          mem_to_reg = M2R_MDR;
          pc_update  = 1'b1;
          alu_src_b  = SRC_B_FOUR;
          next_state = S_IF;
        end
        S_MEM_ST: begin
          // The address comes from ALUOut, so the ALU is free for PC+4 in the ready cycle.
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (mem_ready) begin
            pc_update  = 1'b1;
            alu_src_b  = SRC_B_FOUR;
            next_state = S_IF;
          end
        end
        S_EX_BR: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_OP_BRANCH;
          pc_source  = 1'b1;
          pc_update  = alu_bcond;
          next_state = alu_bcond ? S_IF : S_PC4;
        end
        S_EX_JAL, S_WB_JALR: begin
          // Live ALU computes the link address while PC loads the target held in ALUOut.
          alu_src_b  = SRC_B_FOUR;
          mem_to_reg = M2R_ALU;
          reg_write  = 1'b1;
          pc_source  = 1'b1;
          pc_update  = 1'b1;
          next_state = S_IF;
        end
        S_PC4: begin
          pc_update  = 1'b1;
          alu_src_b  = SRC_B_FOUR;
          next_state = S_IF;
        end
        S_HALT: begin
          is_halted = 1'b1;
        end
        default: next_state = S_IF;
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_STATS_EN
  logic cycle_inc, instret_inc;

  assign cycle_inc   = (state != S_HALT);
  // Retirement: every return to IF, plus the ECALL that halts the machine.
  assign instret_inc = ((next_state == S_IF) && (state != S_IF)) ||
                       ((state == S_ID) && (next_state == S_HALT) && (opcode == OPC_SYSTEM));

  ctrl_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk        (clk),
    .reset      (reset),
    .cycle_inc  (cycle_inc),
    .instret_inc(instret_inc),
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
  );
`endif

endmodule
